// File: rtl/jtframe_psg_mixfilt.sv
// Multi-channel PSG mixer: per-channel 4.4 gain through one shared multiplier,
// saturation, leaky-integrator DC removal and an optional one-pole low-pass.
module jtframe_psg_mixfilt #(
  parameter int unsigned CH   = 3,
  parameter int unsigned DW   = 10,
  parameter int unsigned DCSH = 8,
  parameter int unsigned LPSH = 2
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 sample,
  input  logic [CH*DW-1:0]     din,
  input  logic [CH*8-1:0]      gain,
  input  logic                 lpf_en,
  output logic signed [15:0]   dout,
  output logic                 dout_valid,
  output logic                 busy,
  output logic                 overrun
);

  localparam int unsigned ChW = (CH > 1) ? $clog2(CH) : 1;
  localparam int unsigned SW  = DW + $clog2(CH);
  localparam int unsigned AW  = DW + 8 + $clog2(CH);
  localparam int unsigned PW  = DW + 8;
  localparam int unsigned YW  = SW + 1;
  // DC estimate keeps DCSH fraction bits plus one guard bit above the signed range
  localparam int unsigned DcW = SW + 2 + DCSH;

  if (SW > 15) begin : g_sw_check
    $error("jtframe_psg_mixfilt: DW + clog2(CH) must not exceed 15");
  end
  if (CH < 1 || CH > 8) begin : g_ch_check
    $error("jtframe_psg_mixfilt: CH must be in 1..8");
  end

  typedef enum logic [2:0] {
    StIdle,
    StMac,
    StSat,
    StDcrm,
    StLpf,
    StOut
  } state_e;

  state_e state_q, state_d;

  // Snapshots taken when a conversion is accepted
  logic [DW-1:0] din_s  [CH];
  logic [7:0]    gain_s [CH];
  logic          lpf_en_s;

  logic [ChW-1:0]        ch_q;
  logic [AW-1:0]         acc_q;
  logic signed [YW-1:0]  m_q;
  logic signed [YW-1:0]  y_q;
  logic signed [DcW-1:0] dc_q;
  logic signed [YW-1:0]  lp_q;

  // Combinational datapath
  logic [PW-1:0]         prod;
  logic [AW-1:0]         acc_sum;
  logic [AW-5:0]         acc_shr;
  logic [SW-1:0]         m_sat;
  logic signed [DcW-1:0] dc_shr;
  logic signed [YW-1:0]  dc_int;
  logic signed [YW-1:0]  y_new;
  logic signed [DcW-1:0] m_ext;
  logic signed [DcW-1:0] dc_err;
  logic signed [DcW-1:0] dc_step;
  logic signed [DcW-1:0] dc_next;
  logic signed [YW:0]    lp_err;
  logic signed [YW:0]    lp_step;
  logic signed [YW-1:0]  lp_next;
  logic signed [15:0]    z_ext;
  logic signed [15:0]    dout_d;

  assign busy = (state_q != StIdle);

  // Shared multiplier, MAC, saturation and filter arithmetic
  always_comb begin
    prod    = PW'(din_s[ch_q]) * PW'(gain_s[ch_q]);
    acc_sum = acc_q + AW'(prod);
    acc_shr = acc_q[AW-1:4];
    if (acc_shr[AW-5:SW] != '0) begin
      m_sat = '1;
    end else begin
      m_sat = acc_shr[SW-1:0];
    end
    // Integer part of the DC estimate; the old value is used for y
    dc_shr  = dc_q >>> DCSH;
    dc_int  = dc_shr[YW-1:0];
    y_new   = m_q - dc_int;
    m_ext   = DcW'(m_q);
    dc_err  = (m_ext <<< DCSH) - dc_q;
    dc_step = dc_err >>> DCSH;
    dc_next = dc_q + dc_step;
    lp_err  = {y_q[YW-1], y_q} - {lp_q[YW-1], lp_q};
    lp_step = lp_err >>> LPSH;
    lp_next = lp_q + lp_step[YW-1:0];
    // lp always holds z, whether the low-pass is bypassed or not
    z_ext   = 16'(lp_q);
    dout_d  = z_ext <<< (15 - SW);
  end

  // Next-state decode
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:  if (sample) state_d = StMac;
      StMac:   if (ch_q == ChW'(CH - 1)) state_d = StSat;
      StSat:   state_d = StDcrm;
      StDcrm:  state_d = StLpf;
      StLpf:   state_d = StOut;
      StOut:   state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // State register
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // Input snapshots; only loaded on an accepted strobe so no reset is needed
  always_ff @(posedge clk) begin
    if (rst_n && state_q == StIdle && sample) begin
      for (int k = 0; k < int'(CH); k++) begin
        din_s[k]  <= din[k*DW +: DW];
        gain_s[k] <= gain[k*8 +: 8];
      end
      lpf_en_s <= lpf_en;
    end
  end

  // Datapath registers and output strobes
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ch_q       <= '0;
      acc_q      <= '0;
      m_q        <= '0;
      y_q        <= '0;
      dc_q       <= '0;
      lp_q       <= '0;
      dout       <= '0;
      dout_valid <= 1'b0;
      overrun    <= 1'b0;
    end else begin
      dout_valid <= 1'b0;
      overrun    <= sample && (state_q != StIdle);
      unique case (state_q)
        StIdle: begin
          if (sample) begin
            acc_q <= '0;
            ch_q  <= '0;
          end
        end
        StMac: begin
          acc_q <= acc_sum;
          ch_q  <= ch_q + ChW'(1);
        end
        StSat: begin
          m_q <= $signed({1'b0, m_sat});
        end
        StDcrm: begin
          y_q  <= y_new;
          dc_q <= dc_next;
        end
        StLpf: begin
          lp_q <= lpf_en_s ? lp_next : y_q;
        end
        StOut: begin
          dout       <= dout_d;
          dout_valid <= 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_jtframe_psg_mixfilt.sv
// Randomised self-checking bench for jtframe_psg_mixfilt against an arithmetic model.
module tb_jtframe_psg_mixfilt;

  localparam int CH   = 3;
  localparam int DW   = 10;
  localparam int DCSH = 8;
  localparam int LPSH = 2;
  localparam int SW   = 12;

  logic               clk = 1'b0;
  logic               rst_n = 1'b0;
  logic               sample = 1'b0;
  logic [CH*DW-1:0]   din = '0;
  logic [CH*8-1:0]    gain = '0;
  logic               lpf_en = 1'b0;
  logic signed [15:0] dout;
  logic               dout_valid;
  logic               busy;
  logic               overrun;

  int total  = 0;
  int passed = 0;

  // Model state: DC estimate scaled by 2^DCSH, and low-pass state
  longint mdcf = 0;
  longint mlp  = 0;

  jtframe_psg_mixfilt #(
    .CH  (CH),
    .DW  (DW),
    .DCSH(DCSH),
    .LPSH(LPSH)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .sample    (sample),
    .din       (din),
    .gain      (gain),
    .lpf_en    (lpf_en),
    .dout      (dout),
    .dout_valid(dout_valid),
    .busy      (busy),
    .overrun   (overrun)
  );

  always #5 clk = ~clk;

  task automatic model_step(input int dv[CH], input int gv[CH], input bit lpf,
                            output longint res);
    longint sum, m, y;
    sum = 0;
    for (int k = 0; k < CH; k++) sum += longint'(dv[k]) * longint'(gv[k]);
    m = sum / 16;
    if (m > (2**SW) - 1) m = (2**SW) - 1;
    y = m - (mdcf >>> DCSH);
    mdcf = mdcf + ((m * (2**DCSH) - mdcf) >>> DCSH);
    if (lpf) mlp = mlp + ((y - mlp) >>> LPSH);
    else mlp = y;
    res = mlp * (2**(15 - SW));
  endtask

  task automatic drive(input int dv[CH], input int gv[CH], input bit lpf);
    for (int k = 0; k < CH; k++) begin
      din[k*DW +: DW] = dv[k][DW-1:0];
      gain[k*8 +: 8]  = gv[k][7:0];
    end
    lpf_en = lpf;
  endtask

  task automatic scramble();
    logic [63:0] r;
    r      = {$urandom(), $urandom()};
    din    = r[CH*DW-1:0];
    r      = {$urandom(), $urandom()};
    gain   = r[CH*8-1:0];
    lpf_en = ~lpf_en;
  endtask

  // Runs one conversion, scrambling inputs after acceptance
  task automatic do_conv(input int dv[CH], input int gv[CH], input bit lpf,
                         output int lat, output logic signed [15:0] got,
                         output int ovr, output bit busy1);
    drive(dv, gv, lpf);
    sample = 1'b1;
    @(posedge clk); #1;
    sample = 1'b0;
    busy1 = busy;
    scramble();
    lat = -1;
    ovr = 0;
    got = 'x;
    for (int k = 1; k <= 20; k++) begin
      @(posedge clk); #1;
      if (overrun) ovr++;
      if (dout_valid) begin
        lat = k;
        got = dout;
        break;
      end
    end
  endtask

  task automatic do_reset(input int cycles);
    rst_n = 1'b0;
    for (int k = 0; k < cycles; k++) begin
      sample = k[0];
      @(posedge clk); #1;
    end
    sample = 1'b0;
    rst_n = 1'b1;
    mdcf = 0;
    mlp  = 0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    for (int k = 0; k < 3; k++) begin
      sample = ~sample;
      @(posedge clk); #1;
      total++;
      if (dout !== 16'sd0 || dout_valid !== 1'b0 || busy !== 1'b0 || overrun !== 1'b0) begin
        $display("FAIL reset_outputs cycle %0d: dout=%0d valid=%b busy=%b ovr=%b, want 0/0/0/0",
                 k, dout, dout_valid, busy, overrun);
      end else passed++;
    end
    sample = 1'b0;
    rst_n = 1'b1;
    mdcf = 0;
    mlp  = 0;
  endtask

  task automatic test_dc_step();
    int dv[CH], gv[CH], lat, ovr;
    bit b1;
    logic signed [15:0] got;
    longint exp;
    for (int k = 0; k < CH; k++) begin dv[k] = 512; gv[k] = 16; end
    do_conv(dv, gv, 1'b0, lat, got, ovr, b1);
    model_step(dv, gv, 1'b0, exp);
    total++;
    if (lat !== 7) $display("FAIL dc_latency: got %0d clocks, want 7", lat);
    else passed++;
    total++;
    if (b1 !== 1'b1) $display("FAIL busy_during_conv: got %b, want 1", b1);
    else passed++;
    total++;
    if (got !== 16'sd12288 || longint'(got) != exp)
      $display("FAIL dc_first: got %0d, want 12288 (model %0d)", got, exp);
    else passed++;
    // dout holds and valid is a single-cycle pulse
    @(posedge clk); #1;
    total++;
    if (dout_valid !== 1'b0 || dout !== got)
      $display("FAIL dc_hold: valid=%b dout=%0d, want 0 and %0d", dout_valid, dout, got);
    else passed++;
    do_conv(dv, gv, 1'b0, lat, got, ovr, b1);
    model_step(dv, gv, 1'b0, exp);
    total++;
    if (got !== 16'sd12240 || longint'(got) != exp)
      $display("FAIL dc_second: got %0d, want 12240 (model %0d)", got, exp);
    else passed++;
    for (int n = 0; n < 2000; n++) begin
      do_conv(dv, gv, 1'b0, lat, got, ovr, b1);
      model_step(dv, gv, 1'b0, exp);
      total++;
      if (lat !== 7 || ovr != 0 || longint'(got) != exp)
        $display("FAIL dc_settle[%0d]: got %0d lat %0d ovr %0d, want %0d lat 7 ovr 0",
                 n, got, lat, ovr, exp);
      else passed++;
    end
    total++;
    if (got > 16'sd63 || got < -16'sd63) $display("FAIL dc_removed: got %0d, want |dout|<64", got);
    else passed++;
  endtask

  task automatic test_saturation();
    int dv[CH], gv[CH], lat, ovr;
    bit b1;
    logic signed [15:0] got;
    longint exp;
    do_reset(2);
    for (int k = 0; k < CH; k++) begin dv[k] = 1023; gv[k] = 255; end
    do_conv(dv, gv, 1'b0, lat, got, ovr, b1);
    model_step(dv, gv, 1'b0, exp);
    total++;
    if (got !== 16'sd32760 || longint'(got) != exp)
      $display("FAIL saturation: got %0d, want 32760 (model %0d)", got, exp);
    else passed++;
  endtask

  task automatic test_lowpass();
    int dv[CH], gv[CH], lat, ovr;
    bit b1;
    logic signed [15:0] got;
    longint exp;
    do_reset(2);
    for (int k = 0; k < CH; k++) begin dv[k] = 512; gv[k] = 16; end
    do_conv(dv, gv, 1'b1, lat, got, ovr, b1);
    model_step(dv, gv, 1'b1, exp);
    total++;
    if (got !== 16'sd3072 || longint'(got) != exp)
      $display("FAIL lpf_first: got %0d, want 3072 (model %0d)", got, exp);
    else passed++;
    do_conv(dv, gv, 1'b1, lat, got, ovr, b1);
    model_step(dv, gv, 1'b1, exp);
    total++;
    if (got !== 16'sd5360 || longint'(got) != exp)
      $display("FAIL lpf_second: got %0d, want 5360 (model %0d)", got, exp);
    else passed++;
  endtask

  task automatic test_random();
    int dv[CH], gv[CH], lat, ovr, gap;
    bit b1, lpf;
    logic signed [15:0] got;
    longint exp;
    for (int n = 0; n < 200; n++) begin
      for (int k = 0; k < CH; k++) begin
        dv[k] = int'($urandom_range(1023, 0));
        gv[k] = int'($urandom_range(255, 0));
      end
      lpf = 1'($urandom_range(1, 0));
      gap = int'($urandom_range(3, 0));
      repeat (gap) begin @(posedge clk); #1; end
      do_conv(dv, gv, lpf, lat, got, ovr, b1);
      model_step(dv, gv, lpf, exp);
      total++;
      if (lat !== 7 || longint'(got) != exp)
        $display("FAIL random[%0d]: got %0d lat %0d, want %0d lat 7", n, got, lat, exp);
      else passed++;
    end
  endtask

  task automatic test_overrun();
    int dv[CH], gv[CH], nv, no;
    logic signed [15:0] got;
    longint exp;
    do_reset(2);
    for (int k = 0; k < CH; k++) begin dv[k] = 512; gv[k] = 16; end
    drive(dv, gv, 1'b0);
    sample = 1'b1;
    @(posedge clk); #1;
    sample = 1'b0;
    scramble();
    nv = 0;
    no = 0;
    got = 'x;
    for (int k = 1; k <= 25; k++) begin
      sample = (k == 3);
      @(posedge clk); #1;
      if (overrun) no++;
      if (dout_valid) begin nv++; got = dout; end
    end
    sample = 1'b0;
    model_step(dv, gv, 1'b0, exp);
    total++;
    if (no != 1) $display("FAIL overrun_pulses: got %0d, want 1", no);
    else passed++;
    total++;
    if (nv != 1) $display("FAIL overrun_valids: got %0d, want 1", nv);
    else passed++;
    total++;
    if (longint'(got) != exp) $display("FAIL overrun_dout: got %0d, want %0d", got, exp);
    else passed++;
  endtask

  task automatic test_back_to_back();
    int dv[CH], gv[CH], lat, ovr;
    bit b1;
    logic signed [15:0] got;
    longint exp;
    for (int n = 0; n < 4; n++) begin
      for (int k = 0; k < CH; k++) begin
        dv[k] = int'($urandom_range(1023, 0));
        gv[k] = int'($urandom_range(255, 0));
      end
      do_conv(dv, gv, 1'b1, lat, got, ovr, b1);
      model_step(dv, gv, 1'b1, exp);
      total++;
      if (ovr != 0 || lat !== 7 || longint'(got) != exp)
        $display("FAIL back_to_back[%0d]: got %0d lat %0d ovr %0d, want %0d lat 7 ovr 0",
                 n, got, lat, ovr, exp);
      else passed++;
    end
  endtask

  task automatic test_mid_reset();
    int dv[CH], gv[CH], lat, ovr, nv;
    bit b1;
    logic signed [15:0] got;
    longint exp;
    for (int k = 0; k < CH; k++) begin dv[k] = 512; gv[k] = 16; end
    do_conv(dv, gv, 1'b1, lat, got, ovr, b1);
    drive(dv, gv, 1'b1);
    sample = 1'b1;
    @(posedge clk); #1;
    sample = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    mdcf = 0;
    mlp  = 0;
    nv = 0;
    for (int k = 0; k < 15; k++) begin
      @(posedge clk); #1;
      if (dout_valid) nv++;
    end
    total++;
    if (nv != 0) $display("FAIL midreset_no_valid: got %0d pulses, want 0", nv);
    else passed++;
    do_conv(dv, gv, 1'b1, lat, got, ovr, b1);
    model_step(dv, gv, 1'b1, exp);
    total++;
    if (got !== 16'sd3072 || longint'(got) != exp)
      $display("FAIL midreset_fresh: got %0d, want 3072 (model %0d)", got, exp);
    else passed++;
  endtask

  initial begin
    test_reset();
    test_dc_step();
    test_saturation();
    test_lowpass();
    test_random();
    test_overrun();
    test_back_to_back();
    test_mid_reset();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
